// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Central hazard controller for the pipelined CPU: load-use stall,
//   branch/jump flush window, multi-cycle execute sequencer, N-deep
//   forwarding-source selection and a saturating stall-cycle counter.
//
// Ports
//   Clock, Reset            pipeline clock, asynchronous active-high reset
//   ID_*                    source operands / jump of the instruction in ID
//   EX_*                    operands, destination and control of the EX stage
//   Fwd_RegDest/RegWrite    flattened destinations of the forwarding stages
//                           (slice k = stage k, k = 0 is nearest)
//   MC_Start, MC_Latency    multi-cycle op issue and its latency
//   *_WriteEnable           pipeline register / PC enables
//   IFID_Flush, IDEX_Flush  flush controls, EXMEM_Bubble bubble into EX/MEM
//   FwdSelA/B               0 = register file, k+1 = forwarding stage k
//   MC_Busy, MC_Done        sequencer status, MC_Done is a one-cycle pulse
//   StallCycles             saturating count of cycles with PC frozen
module pipe_hazard_ctrl #(
    parameter int          ADDR_W       = 5,
    parameter int          FWD_STAGES   = 2,
    parameter int          SEL_W        = 2,
    parameter int          CNT_W        = 5,
    parameter int          FLUSH_CYCLES = 1,
    // Reset value of StallCycles; 0 for normal builds.
    parameter logic [31:0] STALL_INIT   = '0
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic [ADDR_W-1:0]            ID_Rs,
    input  logic [ADDR_W-1:0]            ID_Rt,
    input  logic                         ID_UsesRs,
    input  logic                         ID_UsesRt,
    input  logic                         ID_Jump,
    input  logic [ADDR_W-1:0]            EX_Rs,
    input  logic [ADDR_W-1:0]            EX_Rt,
    input  logic [ADDR_W-1:0]            EX_RegDest,
    input  logic                         EX_RegWrite,
    input  logic                         EX_MemRead,
    input  logic                         EX_BranchTaken,
    input  logic [FWD_STAGES*ADDR_W-1:0] Fwd_RegDest,
    input  logic [FWD_STAGES-1:0]        Fwd_RegWrite,
    input  logic                         MC_Start,
    input  logic [CNT_W-1:0]             MC_Latency,
    output logic                         PC_WriteEnable,
    output logic                         IFID_WriteEnable,
    output logic                         IDEX_WriteEnable,
    output logic                         IFID_Flush,
    output logic                         IDEX_Flush,
    output logic                         EXMEM_Bubble,
    output logic [SEL_W-1:0]             FwdSelA,
    output logic [SEL_W-1:0]             FwdSelB,
    output logic                         MC_Busy,
    output logic                         MC_Done,
    output logic [31:0]                  StallCycles
);

    // Sequencer state encodings.
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Flush counter only has to hold FLUSH_CYCLES-1.
    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    logic [1:0]       state;
    logic [CNT_W-1:0] mc_cnt;
    logic [FC_W-1:0]  flush_cnt;
    logic [31:0]      stall_cnt;

    logic busy;
    logic branch;
    logic load_use;
    logic rs_hit;
    logic rt_hit;

    assign busy   = (state == BUSY);
    assign branch = EX_BranchTaken && !busy;

    assign rs_hit   = ID_UsesRs && (ID_Rs == EX_RegDest);
    assign rt_hit   = ID_UsesRt && (ID_Rt == EX_RegDest);
    assign load_use = EX_MemRead && EX_RegWrite && (EX_RegDest != '0) && (rs_hit || rt_hit);

    // ------------------------------------------------------------------
    // Pipeline control, in priority order Reset > BUSY > branch > load-use
    // > jump. The branch flush window keeps IF/ID flushed underneath a
    // load-use stall or a jump, but is masked while the pipe is frozen.
    // ------------------------------------------------------------------
    always_comb begin
        PC_WriteEnable   = 1'b1;
        IFID_WriteEnable = 1'b1;
        IDEX_WriteEnable = 1'b1;
        IFID_Flush       = 1'b0;
        IDEX_Flush       = 1'b0;
        EXMEM_Bubble     = 1'b0;
        if (Reset) begin
            PC_WriteEnable   = 1'b0;
            IFID_WriteEnable = 1'b0;
            IDEX_WriteEnable = 1'b0;
            IFID_Flush       = 1'b1;
            IDEX_Flush       = 1'b1;
        end else if (busy) begin
            PC_WriteEnable   = 1'b0;
            IFID_WriteEnable = 1'b0;
            IDEX_WriteEnable = 1'b0;
            EXMEM_Bubble     = 1'b1;
        end else if (branch) begin
            IFID_Flush = 1'b1;
            IDEX_Flush = 1'b1;
        end else begin
            if (flush_cnt != '0) begin
                IFID_Flush = 1'b1;
            end
            if (load_use) begin
                PC_WriteEnable   = 1'b0;
                IFID_WriteEnable = 1'b0;
                IDEX_Flush       = 1'b1;
            end else if (ID_Jump) begin
                IFID_Flush = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Forwarding select: nearest writing stage wins, $0 never forwards.
    // ------------------------------------------------------------------
    always_comb begin
        logic found_a;
        logic found_b;
        FwdSelA = '0;
        FwdSelB = '0;
        found_a = 1'b0;
        found_b = 1'b0;
        if (!Reset) begin
            for (int unsigned k = 0; k < FWD_STAGES; k++) begin
                if (!found_a && Fwd_RegWrite[k] && (EX_Rs != '0) &&
                    (Fwd_RegDest[k*ADDR_W +: ADDR_W] == EX_Rs)) begin
                    FwdSelA = SEL_W'(k + 1);
                    found_a = 1'b1;
                end
                if (!found_b && Fwd_RegWrite[k] && (EX_Rt != '0) &&
                    (Fwd_RegDest[k*ADDR_W +: ADDR_W] == EX_Rt)) begin
                    FwdSelB = SEL_W'(k + 1);
                    found_b = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Multi-cycle sequencer. A latency of L yields exactly L BUSY cycles;
    // zero latency is promoted to one.
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state  <= IDLE;
            mc_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (MC_Start) begin
                        mc_cnt <= (MC_Latency == '0) ? CNT_W'(1) : MC_Latency;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    mc_cnt <= mc_cnt - 1'b1;
                    if (mc_cnt == CNT_W'(1)) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign MC_Busy = (state == BUSY) || (state == DONE);
    assign MC_Done = (state == DONE);

    // ------------------------------------------------------------------
    // Branch flush window. Frozen while BUSY so the window resumes once
    // the pipe moves again.
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            flush_cnt <= '0;
        end else if (!busy) begin
            if (branch) begin
                flush_cnt <= FC_W'(FLUSH_CYCLES - 1);
            end else if (flush_cnt != '0) begin
                flush_cnt <= flush_cnt - 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturating stall counter for the debug display.
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            stall_cnt <= STALL_INIT;
        end else if (!PC_WriteEnable && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign StallCycles = stall_cnt;

endmodule
